// File: rtl/lw_sw_addi_encoder.sv
// lw_sw_addi_encoder: packs LW/SW/ADDI requests into RV32I I/S-type words,
// range-checks the 12-bit signed immediate and tags each word with an
// auto-incrementing instruction-memory address. Rejected requests are
// counted in a sticky, saturating error counter.
module lw_sw_addi_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_load_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              err,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [1:0] OP_LW   = 2'b00;
  localparam logic [1:0] OP_SW   = 2'b01;
  localparam logic [1:0] OP_ADDI = 2'b10;

  // The immediate fits the 12-bit signed field when bits 31..11 are all equal.
  function automatic logic imm_fits(input logic [31:0] v);
    return (&v[31:11]) || (~|v[31:11]);
  endfunction

  // Pack one request; rs2 is ignored for LW/ADDI and rd for SW.
  function automatic logic [31:0] encode(input logic [1:0]  op,
                                         input logic [4:0]  f_rd,
                                         input logic [4:0]  f_rs1,
                                         input logic [4:0]  f_rs2,
                                         input logic [11:0] f_imm);
    logic [31:0] w;
    w = '0;
    case (op)
      OP_LW:   w = {f_imm, f_rs1, 3'b010, f_rd, 7'b0000011};
      OP_SW:   w = {f_imm[11:5], f_rs2, f_rs1, 3'b010, f_imm[4:0], 7'b0100011};
      OP_ADDI: w = {f_imm, f_rs1, 3'b000, f_rd, 7'b0010011};
      default: w = '0;
    endcase
    return w;
  endfunction

  // Error counter increment that holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic              vld_p0;
  logic [31:0]       instr_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [ADDR_W-1:0] next_addr;
  logic              err_q;
  logic [CNT_W-1:0]  err_cnt_q;

  logic              accept;
  logic              legal_acc;
  logic              illegal_acc;
  logic [ADDR_W-1:0] addr_base;
  logic [31:0]       word;

  // Handshake decode, address selection and packing for the incoming request.
  always_comb begin
    in_ready    = !vld_p0 || out_ready;
    accept      = in_valid && in_ready;
    legal_acc   = accept && (op_sel != 2'b11) && imm_fits(imm);
    illegal_acc = accept && !legal_acc;
    addr_base   = addr_load ? addr_load_val : next_addr;
    word        = encode(op_sel, rd, rs1, rs2, imm[11:0]);
  end

  // ---- stage p0: output register, address counter and error state ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      instr_p0  <= '0;
      addr_p0   <= BASE_ADDR;
      next_addr <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (legal_acc) begin
        vld_p0    <= 1'b1;
        instr_p0  <= word;
        addr_p0   <= addr_base;
        next_addr <= addr_base + ADDR_W'(4);
      end else begin
        if (out_ready) vld_p0 <= 1'b0;
        if (addr_load) next_addr <= addr_load_val;
      end
      if (illegal_acc) begin
        err_q     <= 1'b1;
        err_cnt_q <= sat_inc(err_cnt_q);
      end
    end
  end

  assign out_valid  = vld_p0;
  assign instr      = instr_p0;
  assign instr_addr = addr_p0;
  assign err        = err_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_lw_sw_addi_encoder.sv
// Randomized self-checking bench for lw_sw_addi_encoder (ADDR_W=8, CNT_W=2).
module tb_lw_sw_addi_encoder;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op_sel;
  logic [4:0]        rd, rs1, rs2;
  logic [31:0]       imm;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_load_val;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_addr;
  logic              err;
  logic [CNT_W-1:0]  err_count;

  lw_sw_addi_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(8'h00), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .addr_load(addr_load), .addr_load_val(addr_load_val),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .instr_addr(instr_addr), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state, kept as plain integers.
  int m_ov, m_instr, m_addr, m_next, m_err, m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Encoding from the instruction-format rules using shifts and masks.
  function automatic int ref_word(input int op, input int f_rd, input int f_rs1,
                                  input int f_rs2, input int f_imm);
    int i12;
    i12 = f_imm & 'hFFF;
    if (op == 0) return (i12 << 20) | (f_rs1 << 15) | (2 << 12) | (f_rd << 7) | 'h03;
    if (op == 1) return (((i12 >> 5) & 'h7F) << 25) | (f_rs2 << 20) | (f_rs1 << 15)
                        | (2 << 12) | ((i12 & 'h1F) << 7) | 'h23;
    return (i12 << 20) | (f_rs1 << 15) | (f_rd << 7) | 'h13;
  endfunction

  task automatic model_reset();
    m_ov = 0; m_instr = 0; m_addr = 0; m_next = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    if (m_ov != 0) begin
      check({tag, ".instr"}, instr, m_instr);
      check({tag, ".instr_addr"}, 32'(instr_addr), 32'(m_addr));
    end
    check({tag, ".err"}, 32'(err), 32'(m_err));
    check({tag, ".err_count"}, 32'(err_count), 32'(m_cnt));
  endtask

  // One clock cycle: drive, check in_ready, advance model, check outputs.
  task automatic step(input string tag, input bit v, input int op, input int f_rd,
                      input int f_rs1, input int f_rs2, input int f_imm,
                      input bit ld, input int ldv, input bit ordy);
    bit acc, legal;
    int base;
    in_valid = v; op_sel = op[1:0]; rd = f_rd[4:0]; rs1 = f_rs1[4:0];
    rs2 = f_rs2[4:0]; imm = f_imm; addr_load = ld; addr_load_val = ldv[7:0];
    out_ready = ordy;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'((m_ov == 0 || ordy) ? 1 : 0));
    acc   = v && (m_ov == 0 || ordy);
    legal = acc && op != 3 && f_imm >= -2048 && f_imm <= 2047;
    base  = ld ? (ldv & 'hFF) : m_next;
    if (legal) begin
      m_ov = 1; m_instr = ref_word(op, f_rd, f_rs1, f_rs2, f_imm);
      m_addr = base; m_next = (base + 4) % 256;
    end else begin
      if (ordy) m_ov = 0;
      if (ld) m_next = ldv & 'hFF;
    end
    if (acc && !legal) begin
      m_err = 1;
      if (m_cnt < 3) m_cnt++;
    end
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 0;
    in_valid = 1; op_sel = 2'b10; rd = 5'd1; rs1 = 5'd2; rs2 = 5'd3; imm = 32'd7;
    addr_load = 0; addr_load_val = '0; out_ready = 1;
    @(posedge clk); #1;
    rst_n = 1;
    in_valid = 0;
    model_reset();
    check_outputs(tag);
    check({tag, ".instr_rst"}, instr, 32'h0);
    check({tag, ".addr_rst"}, 32'(instr_addr), 32'h0);
    check({tag, ".in_ready"}, 32'(in_ready), 32'h1);
  endtask

  function automatic int rand_imm();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 6) return int'($urandom_range(0, 4095)) - 2048;
    if (sel == 6) return 2047 + int'($urandom_range(0, 1));
    if (sel == 7) return -2048 - int'($urandom_range(0, 1));
    return int'($urandom);
  endfunction

  initial begin
    rst_n = 0; in_valid = 0; op_sel = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;
    addr_load = 0; addr_load_val = 0; out_ready = 0;
    model_reset();
    @(posedge clk);
    do_reset("reset");

    // Basic ADDI with imm = -1
    step("addi", 1, 2, 5, 6, 0, -1, 0, 0, 1);
    check("addi_word", instr, 32'hFFF30293);
    check("addi_addr", 32'(instr_addr), 32'h0);

    // Back-to-back LW then SW from a fresh reset
    do_reset("reset2");
    step("lw", 1, 0, 1, 2, 0, 8, 0, 0, 1);
    check("lw_word", instr, 32'h00812083);
    step("sw", 1, 1, 9, 4, 3, 20, 0, 0, 1);
    check("sw_word", instr, 32'h00322A23);
    check("sw_addr", 32'(instr_addr), 32'h4);

    // Range and illegal-op rejections, then the negative boundary
    step("imm2048", 1, 2, 1, 1, 0, 2048, 0, 0, 1);
    step("op11", 1, 3, 1, 1, 0, 5, 0, 0, 1);
    check("op11_cnt", 32'(err_count), 32'h2);
    step("immm2048", 1, 2, 7, 8, 0, -2048, 0, 0, 1);
    check("immm2048_hi", 32'(instr[31:20]), 32'h800);
    check("immm2048_addr", 32'(instr_addr), 32'h8);

    // Backpressure: fill, then hold out_ready low for 5 cycles
    step("bp_fill", 1, 0, 3, 4, 5, 100, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step("bp_hold", 1, $urandom_range(0, 2), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31), 12, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      step("bp_rel", 1, $urandom_range(0, 2), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 31),
           int'($urandom_range(0, 4095)) - 2048, 0, 0, 1);

    // Address load with a legal accept, then wrap to 0
    step("ld_fc", 1, 2, 1, 1, 0, 1, 1, 'hFC, 1);
    check("ld_fc_addr", 32'(instr_addr), 32'hFC);
    step("wrap", 1, 0, 2, 2, 0, 2, 0, 0, 1);
    check("wrap_addr", 32'(instr_addr), 32'h00);

    // Reset in mid-stream discards the held word
    step("pre_rst", 1, 2, 1, 1, 0, 3, 0, 0, 0);
    do_reset("mid_rst");
    step("post_rst", 1, 2, 1, 1, 0, 3, 0, 0, 1);
    check("post_rst_addr", 32'(instr_addr), 32'h00);

    // Counter saturation with five illegal requests
    for (int i = 0; i < 5; i++)
      step("sat", 1, (i % 2 == 0) ? 3 : 2, 1, 1, 0, (i % 2 == 0) ? 0 : 4096, 0, 0, 1);
    check("sat_cnt", 32'(err_count), 32'h3);
    check("sat_err", 32'(err), 32'h1);

    // Randomized traffic
    do_reset("rand_rst");
    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 3),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           rand_imm(), $urandom_range(0, 15) == 0, $urandom_range(0, 255),
           $urandom_range(0, 2) != 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
